pipeline_stall_controller: RTL and testbench

//  Consumer of the ID/EX hazard unit's stall request and the cache handshakes; owns every pipeline register enable.

---
 rtl/pipeline_stall_controller_pkg.sv | 31 +++
 rtl/pipeline_stall_controller_if.sv | 45 ++++
 rtl/pipeline_stall_controller_perf_counters.sv | 33 +++
 rtl/pipeline_stall_controller.sv | 104 ++++++++++
 tb/tb_pipeline_stall_controller.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types for the pipeline stall controller: miss-tracking FSM states and perf counter bundle.
// The perf counter bundle is only consumed when STALL_PERF_CTR_EN is defined.
package pipeline_stall_controller_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_I  = 2'd1,
        WAIT_D  = 2'd2,
        WAIT_ID = 2'd3
    } stall_state_t;

    localparam int PERF_W = 32;

    typedef struct packed {
        logic [PERF_W-1:0] i_stall_cyc;
        logic [PERF_W-1:0] d_stall_cyc;
        logic [PERF_W-1:0] bubbles;
        logic [PERF_W-1:0] flushes;
    } perf_ctr_t;

    // The FSM only remembers which misses are still open this cycle.
    function automatic stall_state_t next_stall_state(input logic i_stall, input logic d_stall);
        case ({i_stall, d_stall})
            2'b10:   return WAIT_I;
            2'b01:   return WAIT_D;
            2'b11:   return WAIT_ID;
            default: return RUN;
        endcase
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard/cache handshake bundle and pipeline enables of the stall controller.
// STALL_PERF_CTR_EN adds the four performance counter outputs.
interface pipeline_stall_controller_if #(
    parameter int CTR_W = 32
);
    logic load_use_stall;
    logic branch_taken;
    logic icache_req;
    logic icache_resp;
    logic dcache_req;
    logic dcache_resp;
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic flush_if_id;
    logic bubble_id_ex;
    logic timeout_err;
`ifdef STALL_PERF_CTR_EN
    logic [CTR_W-1:0] perf_i_stall_cyc;
    logic [CTR_W-1:0] perf_d_stall_cyc;
    logic [CTR_W-1:0] perf_bubbles;
    logic [CTR_W-1:0] perf_flushes;
`endif

    modport master (
        output load_use_stall, branch_taken, icache_req, icache_resp, dcache_req, dcache_resp,
        input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
        input  flush_if_id, bubble_id_ex, timeout_err
`ifdef STALL_PERF_CTR_EN
        , input perf_i_stall_cyc, perf_d_stall_cyc, perf_bubbles, perf_flushes
`endif
    );

    modport slave (
        input  load_use_stall, branch_taken, icache_req, icache_resp, dcache_req, dcache_resp,
        output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
        output flush_if_id, bubble_id_ex, timeout_err
`ifdef STALL_PERF_CTR_EN
        , output perf_i_stall_cyc, perf_d_stall_cyc, perf_bubbles, perf_flushes
`endif
    );

endinterface

// File: rtl/pipeline_stall_controller_perf_counters.sv
// Wrapping per-event cycle counters: bit 0 i_stall, 1 d_stall, 2 bubble, 3 flush.
// Instantiated by the stall controller only when STALL_PERF_CTR_EN is defined.
module stall_perf_counters
    import pipeline_stall_controller_pkg::*;
#(
    parameter int CTR_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    input  logic [3:0] event_vec,
    output perf_ctr_t perf
);

    logic [CTR_W-1:0] cnt_reg [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ctr
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg[gi] <= '0;
                end else if (event_vec[gi]) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CTR_W'(1);
                end
            end
        end
    endgenerate

    assign perf.i_stall_cyc = PERF_W'(cnt_reg[0]);
    assign perf.d_stall_cyc = PERF_W'(cnt_reg[1]);
    assign perf.bubbles     = PERF_W'(cnt_reg[2]);
    assign perf.flushes     = PERF_W'(cnt_reg[3]);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Owns every pipeline register enable: freezes on cache misses, squashes on redirects, bubbles on load-use.
// Optional STALL_PERF_CTR_EN adds stall/bubble/flush performance counters.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CTR_W          = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    pipeline_stall_controller_if.slave  bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    stall_state_t     state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             timeout_reg, timeout_next;
    logic             i_stall, d_stall, freeze;
    logic             bubble_evt, flush_evt;

    assign i_stall = bus.icache_req & ~bus.icache_resp;
    assign d_stall = bus.dcache_req & ~bus.dcache_resp;
    assign freeze  = i_stall | d_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            timeout_reg  <= timeout_next;
        end
    end

    // Counter value is the length of the current uninterrupted wait, including this cycle.
    always_comb begin
        state_next    = next_stall_state(i_stall, d_stall);
        wait_cnt_next = '0;
        if (state_next != RUN) begin
            if (state_reg == RUN) begin
                wait_cnt_next = CNT_W'(1);
            end else if (wait_cnt_reg == CNT_MAX) begin
                wait_cnt_next = wait_cnt_reg;
            end else begin
                wait_cnt_next = wait_cnt_reg + CNT_W'(1);
            end
        end
        timeout_next = timeout_reg | (wait_cnt_next == CNT_MAX);
    end

    always_comb begin
        bus.load_pc      = 1'b1;
        bus.load_if_id   = 1'b1;
        bus.load_id_ex   = 1'b1;
        bus.load_ex_mem  = 1'b1;
        bus.load_mem_wb  = 1'b1;
        bus.flush_if_id  = 1'b0;
        bus.bubble_id_ex = 1'b0;
        bubble_evt       = 1'b0;
        flush_evt        = 1'b0;
        if (rst || freeze) begin
            bus.load_pc     = 1'b0;
            bus.load_if_id  = 1'b0;
            bus.load_id_ex  = 1'b0;
            bus.load_ex_mem = 1'b0;
            bus.load_mem_wb = 1'b0;
        end else if (bus.branch_taken) begin
            // The stalled consumer is on the wrong path, so the redirect beats load-use.
            bus.flush_if_id  = 1'b1;
            bus.bubble_id_ex = 1'b1;
            flush_evt        = 1'b1;
        end else if (bus.load_use_stall) begin
            bus.load_pc      = 1'b0;
            bus.load_if_id   = 1'b0;
            bus.bubble_id_ex = 1'b1;
            bubble_evt       = 1'b1;
        end
    end

    assign bus.timeout_err = timeout_reg;

`ifdef STALL_PERF_CTR_EN
    perf_ctr_t perf;

    stall_perf_counters #(
        .CTR_W (CTR_W)
    ) u_perf (
        .clk       (clk),
        .rst       (rst),
        .event_vec ({flush_evt, bubble_evt, d_stall, i_stall}),
        .perf      (perf)
    );

    assign bus.perf_i_stall_cyc = perf.i_stall_cyc[CTR_W-1:0];
    assign bus.perf_d_stall_cyc = perf.d_stall_cyc[CTR_W-1:0];
    assign bus.perf_bubbles     = perf.bubbles[CTR_W-1:0];
    assign bus.perf_flushes     = perf.flushes[CTR_W-1:0];
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Randomized scoreboard bench for pipeline_stall_controller against a rule-level model.
// Perf counter checks are compiled in when STALL_PERF_CTR_EN is defined.
module tb_pipeline_stall_controller;

    localparam int TMO    = 8;
    localparam int NCYC   = 600;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_stall_controller_if #(.CTR_W(32)) bus ();

    pipeline_stall_controller #(
        .TIMEOUT_CYCLES (TMO),
        .CTR_W          (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [6:0]  ctl;   // {pc, if_id, id_ex, ex_mem, mem_wb, flush, bubble}
        logic        tmo;
        logic [31:0] pi;
        logic [31:0] pd;
        logic [31:0] pb;
        logic [31:0] pf;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;
    bit   started = 0;
    bit   done = 0;

    // Reference model state: length of the current miss run, sticky watchdog, event tallies.
    int          run_len = 0;
    bit          sticky = 0;
    logic [31:0] m_i = 0, m_d = 0, m_b = 0, m_f = 0;

    task automatic drive_and_predict(input int n);
        logic ir, irs, dr, drs, br, lu, r, i_s, d_s, frz;
        exp_t e;
        r   = (n < 2) || (n == 230) || (n > 240 && $urandom_range(0, 199) == 0);
        ir  = ($urandom_range(0, 2) != 0);
        irs = ($urandom_range(0, 3) == 0);
        dr  = ($urandom_range(0, 2) != 0);
        drs = ($urandom_range(0, 3) == 0);
        br  = ($urandom_range(0, 4) == 0);
        lu  = ($urandom_range(0, 3) == 0);
        if (n >= 2 && n < 5) begin
            ir = 0; dr = 0; br = 0; lu = 0;
        end
        if (n >= 200 && n < 216) begin
            ir = 0; dr = 1; drs = 0;
        end
        if (n == 216 || n == 217) begin
            ir = 0; dr = 1; drs = 1;
        end
        rst                = r;
        bus.icache_req     = ir;
        bus.icache_resp    = irs;
        bus.dcache_req     = dr;
        bus.dcache_resp    = drs;
        bus.branch_taken   = br;
        bus.load_use_stall = lu;

        i_s = ir && !irs;
        d_s = dr && !drs;
        frz = i_s || d_s;
        if (r) begin
            run_len = 0; sticky = 0;
            m_i = 0; m_d = 0; m_b = 0; m_f = 0;
            e = '{ctl: 7'b0, tmo: 1'b0, pi: 0, pd: 0, pb: 0, pf: 0};
        end else begin
            if (frz)      e.ctl = 7'b00000_00;
            else if (br)  e.ctl = 7'b11111_11;
            else if (lu)  e.ctl = 7'b00111_01;
            else          e.ctl = 7'b11111_00;
            e.tmo = sticky;
            e.pi = m_i; e.pd = m_d; e.pb = m_b; e.pf = m_f;
            run_len = frz ? run_len + 1 : 0;
            if (run_len >= TMO) sticky = 1;
            if (i_s) m_i++;
            if (d_s) m_d++;
            if (!frz && !br && lu) m_b++;
            if (!frz && br) m_f++;
        end
        sb.push_back(e);
        started = 1;
    endtask

    initial begin
        bus.icache_req = 0; bus.icache_resp = 0;
        bus.dcache_req = 0; bus.dcache_resp = 0;
        bus.branch_taken = 0; bus.load_use_stall = 0;
        for (int n = 0; n < NCYC; n++) begin
            @(posedge clk);
            #1;
            drive_and_predict(n);
        end
        @(posedge clk);
        done = 1;
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : monitor
        int   txn;
        exp_t e;
        logic [6:0] act;
        txn = 0;
        forever begin
            @(negedge clk);
            if (!done && started) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty: txn %0d has no expected entry", txn);
                end else begin
                    e   = sb.pop_front();
                    act = {bus.load_pc, bus.load_if_id, bus.load_id_ex, bus.load_ex_mem,
                           bus.load_mem_wb, bus.flush_if_id, bus.bubble_id_ex};
                    if (act !== e.ctl) begin
                        errors++;
                        $display("FAIL ctl: txn %0d got %b required %b", txn, act, e.ctl);
                    end
                    checks++;
                    if (bus.timeout_err !== e.tmo) begin
                        errors++;
                        $display("FAIL timeout_err: txn %0d got %b required %b", txn, bus.timeout_err, e.tmo);
                    end
`ifdef STALL_PERF_CTR_EN
                    checks++;
                    if ({bus.perf_i_stall_cyc, bus.perf_d_stall_cyc, bus.perf_bubbles, bus.perf_flushes}
                        !== {e.pi, e.pd, e.pb, e.pf}) begin
                        errors++;
                        $display("FAIL perf: txn %0d got %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d", txn,
                                 bus.perf_i_stall_cyc, bus.perf_d_stall_cyc, bus.perf_bubbles,
                                 bus.perf_flushes, e.pi, e.pd, e.pb, e.pf);
                    end
`endif
                    $display("txn %0d rst=%b lu=%b br=%b i=%b%b d=%b%b ctl=%b tmo=%b", txn, rst,
                             bus.load_use_stall, bus.branch_taken, bus.icache_req, bus.icache_resp,
                             bus.dcache_req, bus.dcache_resp, act, bus.timeout_err);
                end
                txn++;
            end
        end
    end

endmodule
